// File: rtl/melody_editor_n.sv
// melody_editor_n: a buffer of DEPTH note entries that is edited one key command at a time.
// Each entry is {dur, oct[1:0], pitch[2:0]}.
//   pitch: 0 is a rest, 1..7 are do..si.
//   oct:   0 mid, 1 low, 2 high. The value 3 is handled as mid and is written back as mid.
// Single-cycle commands: move the cursor, step the pitch (the octave carries), cycle the
// duration. Multi-cycle operations: insert, delete, clear, and a preset load that streams
// words from an external ROM with one cycle of read latency.
//
// Ports:
//   clk100mhz           system clock
//   clr                 synchronous reset, active-high; overrides any operation in progress
//   cmd_valid, cmd      one-cycle key command strobe and opcode
//   cmd_ready           high only when idle
//   clear_req           zero the buffer
//   load_req            load the preset selected by preset_id
//   preset_id           preset to load
//   rom_addr            {preset, index} address driven to the preset ROM
//   rom_data            ROM word, valid one cycle after rom_addr
//   rd_addr, rd_data    combinational player read port
//   cursor, cur_entry   edit position and the entry stored there
//   length              song length in slots, 0..DEPTH
//   busy                an insert, delete, load or clear is in progress
//   edit_pulse          one-cycle pulse when a pitch or duration command changed an entry
module melody_editor_n #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned AW       = 6,
  parameter int unsigned DUR_W    = 2,
  parameter int unsigned PRESET_W = 2,
  localparam int unsigned ENTRY_W = 5 + DUR_W
) (
  input  logic                   clk100mhz,
  input  logic                   clr,
  input  logic                   cmd_valid,
  input  logic [2:0]             cmd,
  output logic                   cmd_ready,
  input  logic                   clear_req,
  input  logic                   load_req,
  input  logic [PRESET_W-1:0]    preset_id,
  output logic [PRESET_W+AW-1:0] rom_addr,
  input  logic [ENTRY_W-1:0]     rom_data,
  input  logic [AW-1:0]          rd_addr,
  output logic [ENTRY_W-1:0]     rd_data,
  output logic [AW-1:0]          cursor,
  output logic [ENTRY_W-1:0]     cur_entry,
  output logic [AW:0]            length,
  output logic                   busy,
  output logic                   edit_pulse
);

  typedef enum logic [2:0] {StIdle, StClear, StLoad, StIns, StDel} state_e;

  localparam logic [2:0] CmdRight   = 3'd1;
  localparam logic [2:0] CmdLeft    = 3'd2;
  localparam logic [2:0] CmdPitchDn = 3'd3;
  localparam logic [2:0] CmdPitchUp = 3'd4;
  localparam logic [2:0] CmdDur     = 3'd5;
  localparam logic [2:0] CmdIns     = 3'd6;
  localparam logic [2:0] CmdDel     = 3'd7;

  localparam logic [1:0] OctMid  = 2'd0;
  localparam logic [1:0] OctLow  = 2'd1;
  localparam logic [1:0] OctHigh = 2'd2;
  localparam logic [1:0] OctBad  = 2'd3;

  localparam logic [AW-1:0] CursorMax = AW'(DEPTH - 1);
  localparam logic [AW:0]   LastIdx   = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   DepthVal  = (AW+1)'(DEPTH);

  state_e                 state_q, state_d;
  logic [ENTRY_W-1:0]     mem_q [DEPTH];
  logic [ENTRY_W-1:0]     mem_d [DEPTH];
  logic [AW-1:0]          cursor_q, cursor_d;
  logic [AW:0]            length_q, length_d;
  logic [AW:0]            idx_q, idx_d;
  logic [PRESET_W-1:0]    preset_q, preset_d;
  logic [PRESET_W+AW-1:0] rom_addr_q, rom_addr_d;
  logic                   edit_pulse_q, edit_pulse_d;

  logic [AW:0]            cur_ext;
  logic [AW:0]            idx_m1;
  logic [AW:0]            idx_p1;

  assign cur_ext = {1'b0, cursor_q};
  assign idx_m1  = idx_q - (AW+1)'(1);
  assign idx_p1  = idx_q + (AW+1)'(1);

  // Result of a pitch or duration command applied to the entry under the cursor.
  logic [2:0]         cur_pitch;
  logic [1:0]         cur_oct;
  logic [DUR_W-1:0]   cur_dur;
  logic [ENTRY_W-1:0] edit_entry;
  logic               edit_en;

  always_comb begin
    cur_pitch = mem_q[cursor_q][2:0];
    cur_oct   = mem_q[cursor_q][4:3];
    cur_dur   = mem_q[cursor_q][ENTRY_W-1:5];
    if (cur_oct == OctBad) begin
      cur_oct = OctMid;
    end
    edit_entry = {cur_dur, cur_oct, cur_pitch};
    edit_en    = 1'b0;
    case (cmd)
      CmdPitchUp: begin
        if (cur_pitch != 3'd7) begin
          edit_entry[2:0] = cur_pitch + 3'd1;
          edit_en         = 1'b1;
        end else if (cur_oct != OctHigh) begin
          edit_entry[2:0] = 3'd0;
          edit_entry[4:3] = (cur_oct == OctLow) ? OctMid : OctHigh;
          edit_en         = 1'b1;
        end
      end
      CmdPitchDn: begin
        if (cur_pitch != 3'd0) begin
          edit_entry[2:0] = cur_pitch - 3'd1;
          edit_en         = 1'b1;
        end else if (cur_oct != OctLow) begin
          edit_entry[2:0] = 3'd7;
          edit_entry[4:3] = (cur_oct == OctHigh) ? OctMid : OctLow;
          edit_en         = 1'b1;
        end
      end
      CmdDur: begin
        edit_entry[ENTRY_W-1:5] = cur_dur + DUR_W'(1);
        edit_en                 = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mem_d        = mem_q;
    cursor_d     = cursor_q;
    length_d     = length_q;
    idx_d        = idx_q;
    preset_d     = preset_q;
    rom_addr_d   = rom_addr_q;
    edit_pulse_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d = StClear;
        end else if (load_req) begin
          state_d    = StLoad;
          preset_d   = preset_id;
          cursor_d   = '0;
          length_d   = '0;
          idx_d      = '0;
          rom_addr_d = {preset_id, AW'(0)};
        end else if (cmd_valid) begin
          case (cmd)
            CmdRight: begin
              if (cursor_q != CursorMax) cursor_d = cursor_q + AW'(1);
            end
            CmdLeft: begin
              if (cursor_q != '0) cursor_d = cursor_q - AW'(1);
            end
            CmdPitchDn, CmdPitchUp, CmdDur: begin
              if (edit_en) begin
                mem_d[cursor_q] = edit_entry;
                edit_pulse_d    = 1'b1;
                // Editing past the end of the song extends it to cover the cursor.
                if (cur_ext >= length_q) length_d = cur_ext + (AW+1)'(1);
              end
            end
            CmdIns: begin
              state_d = StIns;
              idx_d   = LastIdx;
            end
            CmdDel: begin
              state_d = StDel;
              idx_d   = cur_ext;
            end
            default: ;
          endcase
        end
      end

      StClear: begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          mem_d[i] = '0;
        end
        cursor_d = '0;
        length_d = '0;
        state_d  = StIdle;
      end

      StLoad: begin
        // rom_data answers the address issued on the previous cycle.
        if (idx_q != '0) begin
          mem_d[idx_m1[AW-1:0]] = rom_data;
          if (rom_data[2:0] != 3'd0) length_d = idx_q;
        end
        if (idx_q == DepthVal) begin
          state_d = StIdle;
        end else begin
          idx_d      = idx_p1;
          rom_addr_d = {preset_q, idx_p1[AW-1:0]};
        end
      end

      StIns: begin
        // Shift upward from the top so each source slot is read before it is overwritten.
        if (idx_q > cur_ext) begin
          mem_d[idx_q[AW-1:0]] = mem_q[idx_m1[AW-1:0]];
          idx_d                = idx_m1;
        end else begin
          mem_d[cursor_q] = '0;
          if ((cur_ext < length_q) && (length_q != DepthVal)) begin
            length_d = length_q + (AW+1)'(1);
          end
          state_d = StIdle;
        end
      end

      StDel: begin
        if (idx_q < LastIdx) begin
          mem_d[idx_q[AW-1:0]] = mem_q[idx_p1[AW-1:0]];
          idx_d                = idx_p1;
        end else begin
          mem_d[DEPTH-1] = '0;
          if (cur_ext < length_q) length_d = length_q - (AW+1)'(1);
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk100mhz) begin
    if (clr) begin
      state_q      <= StIdle;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      cursor_q     <= '0;
      length_q     <= '0;
      idx_q        <= '0;
      preset_q     <= '0;
      rom_addr_q   <= '0;
      edit_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      cursor_q     <= cursor_d;
      length_q     <= length_d;
      idx_q        <= idx_d;
      preset_q     <= preset_d;
      rom_addr_q   <= rom_addr_d;
      edit_pulse_q <= edit_pulse_d;
    end
  end

  assign cmd_ready  = (state_q == StIdle);
  assign busy       = ~cmd_ready;
  assign rom_addr   = rom_addr_q;
  assign rd_data    = mem_q[rd_addr];
  assign cursor     = cursor_q;
  assign cur_entry  = mem_q[cursor_q];
  assign length     = length_q;
  assign edit_pulse = edit_pulse_q;

endmodule

// File: tb/tb_melody_editor_n.sv
// Directed testbench for melody_editor_n with a scoreboard queue of expected values.
module tb_melody_editor_n;

  localparam logic [2:0] CRight = 3'd1;
  localparam logic [2:0] CLeft  = 3'd2;
  localparam logic [2:0] CDn    = 3'd3;
  localparam logic [2:0] CUp    = 3'd4;
  localparam logic [2:0] CDur   = 3'd5;
  localparam logic [2:0] CIns   = 3'd6;
  localparam logic [2:0] CDel   = 3'd7;

  logic       clk100mhz = 1'b0;
  logic       clr       = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd       = 3'd0;
  logic       clear_req = 1'b0;
  logic       load_req  = 1'b0;
  logic [1:0] preset_id = 2'd0;
  logic [7:0] rom_addr;
  logic [6:0] rom_data;
  logic [5:0] rd_addr   = 6'd0;
  logic [6:0] rd_data;
  logic [5:0] cursor;
  logic [6:0] cur_entry;
  logic [6:0] length;
  logic       cmd_ready;
  logic       busy;
  logic       edit_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  melody_editor_n dut (
    .clk100mhz  (clk100mhz),
    .clr        (clr),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_ready  (cmd_ready),
    .clear_req  (clear_req),
    .load_req   (load_req),
    .preset_id  (preset_id),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cursor     (cursor),
    .cur_entry  (cur_entry),
    .length     (length),
    .busy       (busy),
    .edit_pulse (edit_pulse)
  );

  always #5 clk100mhz = ~clk100mhz;

  // Preset 2 holds pitch (index%7)+1 for index<40 and rests after; other presets are all si.
  function automatic logic [6:0] rom_fn(input logic [7:0] a);
    int idx;
    idx = int'(a[5:0]);
    if (a[7:6] == 2'd2) begin
      if (idx < 40) return 7'((idx % 7) + 1);
      return 7'd0;
    end
    return 7'd7;
  endfunction

  always @(posedge clk100mhz) rom_data <= rom_fn(rom_addr);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk100mhz);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h required nothing", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
    end
  endtask

  task automatic do_cmd(input logic [2:0] c);
    cmd       = c;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd       = 3'd0;
  endtask

  task automatic read_slot(input int a, output logic [6:0] d);
    rd_addr = 6'(a);
    #1;
    d = rd_data;
  endtask

  // Counts busy cycles from the current sample; optionally strobes a command mid-operation.
  task automatic wait_idle(output int n, input bit inject);
    n = 0;
    while (busy && n < 300) begin
      n++;
      if (inject && n == 10) begin
        cmd       = CUp;
        cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    int         pulses;
    int         n;
    logic [6:0] d;

    // 1: reset state, then pitch up through the octave carry to the top of the range.
    tick();
    tick();
    clr = 1'b0;
    expect_v("rst_cursor", 0);     check(32'(cursor));
    expect_v("rst_length", 0);     check(32'(length));
    expect_v("rst_busy", 0);       check(32'(busy));
    expect_v("rst_ready", 1);      check(32'(cmd_ready));
    expect_v("rst_pulse", 0);      check(32'(edit_pulse));
    expect_v("rst_rom_addr", 0);   check(32'(rom_addr));
    expect_v("rst_entry", 0);      check(32'(cur_entry));

    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      expect_v("up_entry", (k < 8) ? k : 'h10);
      do_cmd(CUp);
      if (edit_pulse) pulses++;
      check(32'(cur_entry));
    end
    expect_v("up_pulses", 8);      check(32'(pulses));
    expect_v("up_length", 1);      check(32'(length));
    for (int k = 0; k < 7; k++) do_cmd(CUp);
    expect_v("up_top_entry", 'h17); check(32'(cur_entry));
    expect_v("up_sat_entry", 'h17);
    expect_v("up_sat_pulse", 0);
    do_cmd(CUp);
    check(32'(cur_entry));
    check(32'(edit_pulse));

    // 2: pitch down with octave borrow, duration wrap, cursor saturation.
    do_cmd(CRight);
    expect_v("dn_entry", 'h0F);
    expect_v("dn_pulse", 1);
    expect_v("dn_length", 2);
    do_cmd(CDn);
    check(32'(cur_entry));
    check(32'(edit_pulse));
    check(32'(length));
    for (int k = 0; k < 7; k++) do_cmd(CDn);
    expect_v("dn_bottom", 'h08);   check(32'(cur_entry));
    expect_v("dn_sat_entry", 'h08);
    expect_v("dn_sat_pulse", 0);
    do_cmd(CDn);
    check(32'(cur_entry));
    check(32'(edit_pulse));
    expect_v("dur_step", 'h28);
    do_cmd(CDur);
    check(32'(cur_entry));
    for (int k = 0; k < 3; k++) do_cmd(CDur);
    expect_v("dur_wrap", 'h08);    check(32'(cur_entry));

    for (int k = 0; k < 70; k++) do_cmd(CRight);
    expect_v("right_sat", 63);     check(32'(cursor));
    expect_v("edit_last_len", 64);
    do_cmd(CDur);
    check(32'(length));

    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    expect_v("clr_busy", 1);       check(32'(busy));
    tick();
    expect_v("clr_idle", 0);       check(32'(busy));
    expect_v("clr_length", 0);     check(32'(length));
    expect_v("clr_cursor", 0);     check(32'(cursor));
    read_slot(1, d);
    expect_v("clr_slot1", 0);      check(32'(d));
    do_cmd(CLeft);
    expect_v("left_sat", 0);       check(32'(cursor));

    // 3: insert at cursor 1 into {1,2,3}, with a command strobed mid-operation.
    do_cmd(CUp);
    do_cmd(CRight);
    for (int k = 0; k < 2; k++) do_cmd(CUp);
    do_cmd(CRight);
    for (int k = 0; k < 3; k++) do_cmd(CUp);
    do_cmd(CLeft);
    expect_v("pre_ins_len", 3);    check(32'(length));
    expect_v("ins_busy_cycles", 63);
    do_cmd(CIns);
    wait_idle(n, 1'b1);
    check(32'(n));
    for (int k = 0; k < 4; k++) begin
      expect_v("ins_slot", (k == 0) ? 1 : (k == 1) ? 0 : k);
      read_slot(k, d);
      check(32'(d));
    end
    expect_v("ins_length", 4);     check(32'(length));
    expect_v("ins_cursor", 1);     check(32'(cursor));

    // 4: delete at cursor 1.
    expect_v("del_busy_cycles", 63);
    do_cmd(CDel);
    wait_idle(n, 1'b0);
    check(32'(n));
    for (int k = 0; k < 4; k++) begin
      expect_v("del_slot", (k < 3) ? k + 1 : 0);
      read_slot(k, d);
      check(32'(d));
    end
    read_slot(63, d);
    expect_v("del_slot63", 0);     check(32'(d));
    expect_v("del_length", 3);     check(32'(length));
    expect_v("del_cursor", 1);     check(32'(cursor));

    // 5: preset load; a preset_id change mid-load must be ignored.
    preset_id = 2'd2;
    load_req  = 1'b1;
    tick();
    load_req  = 1'b0;
    preset_id = 2'd1;
    expect_v("load_rom_addr0", 'h80); check(32'(rom_addr));
    expect_v("load_cursor", 0);    check(32'(cursor));
    expect_v("load_busy_cycles", 65);
    wait_idle(n, 1'b0);
    check(32'(n));
    read_slot(39, d);
    expect_v("load_slot39", 5);    check(32'(d));
    read_slot(40, d);
    expect_v("load_slot40", 0);    check(32'(d));
    read_slot(0, d);
    expect_v("load_slot0", 1);     check(32'(d));
    read_slot(7, d);
    expect_v("load_slot7", 1);     check(32'(d));
    expect_v("load_length", 40);   check(32'(length));
    expect_v("load_cursor_end", 0); check(32'(cursor));

    // 6: clr mid-load and mid-insert; clear_req beats load_req.
    preset_id = 2'd2;
    load_req  = 1'b1;
    tick();
    load_req  = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    expect_v("clr_load_busy", 0);  check(32'(busy));
    expect_v("clr_load_len", 0);   check(32'(length));
    expect_v("clr_load_rom", 0);   check(32'(rom_addr));
    read_slot(0, d);
    expect_v("clr_load_slot0", 0); check(32'(d));

    do_cmd(CUp);
    do_cmd(CRight);
    do_cmd(CIns);
    for (int k = 0; k < 5; k++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    expect_v("clr_ins_busy", 0);   check(32'(busy));
    expect_v("clr_ins_cursor", 0); check(32'(cursor));
    expect_v("clr_ins_len", 0);    check(32'(length));
    expect_v("clr_ins_pulse", 0);  check(32'(edit_pulse));
    expect_v("clr_ins_entry", 0);  check(32'(cur_entry));

    do_cmd(CUp);
    clear_req = 1'b1;
    load_req  = 1'b1;
    tick();
    clear_req = 1'b0;
    load_req  = 1'b0;
    expect_v("prio_busy", 1);      check(32'(busy));
    expect_v("prio_rom_addr", 0);  check(32'(rom_addr));
    tick();
    expect_v("prio_idle", 0);      check(32'(busy));
    expect_v("prio_length", 0);    check(32'(length));
    expect_v("prio_entry", 0);     check(32'(cur_entry));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/melody_editor_n.md
Name: melody_editor_n

Overview:
Parametrised melody-buffer editor, successor of the single-song cursor/pitch editor. Holds DEPTH note entries (pitch, octave, duration) in a register array. Applies one-per-cycle key commands: cursor move, pitch up/down with octave carry, duration cycle, and multi-cycle insert/delete. Also clears the buffer or streams a preset from an external ROM, and serves a combinational read port to the player.

Parameters:
DEPTH, 64, number of note slots (power of 2, >=4)
AW, 6, address width, log2(DEPTH)
DUR_W, 2, duration field width (beats = value+1)
PRESET_W, 2, preset selector width

Ports:
clk100mhz  in  1  system clock
clr  in  1  synchronous reset, active-high
cmd_valid  in  1  command strobe (one-cycle pulse, clk100mhz domain)
cmd  in  3  0 NOP, 1 RIGHT, 2 LEFT, 3 PITCH_DN, 4 PITCH_UP, 5 DUR_CYCLE, 6 INSERT, 7 DELETE
cmd_ready  out  1  high only in IDLE
clear_req  in  1  zero the buffer
load_req  in  1  load preset preset_id
preset_id  in  PRESET_W  preset to load
rom_addr  out  PRESET_W+AW  {preset_id, index}
rom_data  in  ENTRY_W  ROM word, valid 1 cycle after rom_addr
rd_addr  in  AW  player read address
rd_data  out  ENTRY_W  entry at rd_addr, combinational
cursor  out  AW  edit position
cur_entry  out  ENTRY_W  entry at cursor
length  out  AW+1  song length in slots, 0..DEPTH
busy  out  1  insert/delete/load/clear in progress
edit_pulse  out  1  one-cycle pulse when an entry changed by PITCH/DUR command (preview trigger)

Behaviour:
- ENTRY_W = 3+2+DUR_W. Entry = {dur, oct[1:0], pitch[2:0]}.
- pitch: 0 = rest, 1..7 = do..si. oct: 0 mid, 1 low, 2 high; 3 is treated as mid on read and written back as 0 on any edit.
- Reset (clr=1 at an edge), overriding everything including mid-operation: all entries 0, cursor 0, length 0, state IDLE, busy 0, edit_pulse 0, rom_addr 0.
- States: IDLE, CLEAR, LOAD, INS, DEL. cmd_ready = (state==IDLE); busy = !cmd_ready.
- Request priority in IDLE: clear_req > load_req > cmd_valid. Requests and commands arriving while busy are dropped, not queued.
- RIGHT: cursor+1, saturates at DEPTH-1. LEFT: cursor-1, saturates at 0.
- PITCH_UP:
  - pitch<7: pitch+1.
  - pitch==7 and oct!=high: pitch=0, oct steps low->mid or mid->high.
  - pitch==7 and oct==high: no change, no edit_pulse.
- PITCH_DN:
  - pitch>0: pitch-1.
  - pitch==0 and oct!=low: pitch=7, oct steps high->mid or mid->low.
  - pitch==0 and oct==low: no change, no edit_pulse.
- DUR_CYCLE: dur+1, wraps 2^DUR_W-1 -> 0.
- Entry update and edit_pulse both occur at the edge following cmd_valid.
- Any PITCH/DUR change with cursor >= length sets length = cursor+1.
- INSERT: IDLE->INS. Index i runs DEPTH-1 down to cursor+1 with mem[i]=mem[i-1], one slot per cycle; then mem[cursor]=0 and return to IDLE.
  - Total busy cycles = DEPTH-cursor.
  - If cursor<length, length = min(length+1, DEPTH). The old mem[DEPTH-1] is discarded.
- DELETE: DEL. Index i runs cursor to DEPTH-2 with mem[i]=mem[i+1]; then mem[DEPTH-1]=0.
  - Busy cycles = DEPTH-cursor.
  - If cursor<length, length-1. Cursor is unchanged.
- CLEAR: zero all entries in one cycle; cursor 0, length 0; 1 busy cycle.
- LOAD: issue rom_addr index 0..DEPTH-1 on consecutive cycles; write rom_data to mem[index-1] one cycle later.
  - Busy cycles = DEPTH+1.
  - Cursor is set to 0 at start.
  - length = 1 + highest index whose loaded pitch!=0, or 0 if all are rests.
  - preset_id is captured at start; changes mid-load are ignored.
- rd_data and cur_entry are combinational from the array. While busy their contents are undefined; the player gates on busy.

Test Plan:
1. clr, then PITCH_UP x8 at cursor 0 -> pitch 1..7, then pitch 0/oct high (entry 0x10). length=1, 8 edit_pulses. Ninth UP at 7/high (after 7 more ups) -> unchanged, no pulse.
2. PITCH_DN from {oct mid, pitch 0} -> {oct low, pitch 7}. Continue DN to 0/low, then DN again -> unchanged. RIGHT x70 -> cursor 63. LEFT at 0 -> stays 0.
3. Write pitches 1,2,3 at slots 0..2; cursor=1; INSERT -> busy exactly 63 cycles; slots = 1,0,2,3; length 4; cmd_valid pulsed mid-op is ignored.
4. From slots 1,0,2,3 with cursor 1: DELETE -> slots 1,2,3, slot 63=0, length 3, busy 63 cycles.
5. load_req with preset_id=2, ROM model returning pitch=(index%7)+1 for index<40 and 0 otherwise -> busy 65 cycles; rd_data(39) pitch 5; length 40; cursor 0.
6. Assert clr mid-LOAD and mid-INSERT -> next cycle all outputs are at reset values. clear_req and load_req together in IDLE -> clear wins, length 0.
